// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and sizing helper for the pipeline hazard unit
//
// Purpose: FSM state encoding, the "no redirect" branch code and the
//          counter-width helper used by pipeline_hazard_unit.
// Contents:
//   hz_state_e  IDLE / LU_STALL / MD_BUSY / FLUSH
//   BR_PC4      branch_ctrl value meaning sequential fetch
//   cnt_w()     counter width able to hold the largest stall length
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE     = 2'd0,
    HZ_LU_STALL = 2'd1,
    HZ_MD_BUSY  = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_state_e;

  localparam logic [1:0] BR_PC4 = 2'b00;

  function automatic int cnt_w(input int load_lat, input int flush_depth, input int md_lat);
    int m;
    m = load_lat;
    if (flush_depth > m) m = flush_depth;
    if (md_lat > m) m = md_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/hz_stall_counter.sv
// rtl/hz_stall_counter.sv - loadable down-counter with hold and zero flag
//
// Purpose: remaining-cycle counter for the multi-cycle hazard states.
// Ports:
//   clk, rst   clock, synchronous active-high reset (cnt -> 0)
//   hold       freeze cnt (wins over load and dec)
//   load       load load_val
//   load_val   reload value
//   dec        decrement by one, saturating at zero
//   cnt        current count
//   zero       cnt == 0
module hz_stall_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (hold) begin
      cnt <= cnt;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - stall/flush controller for the 5-stage RV32 pipeline
//
// Purpose: resolves control redirects (multi-cycle front-end flush), load-use
//          hazards, mul/div occupancy of EX and instruction/data memory wait,
//          driving write enables and flush/bubble controls of PC, IF/ID, ID/EX
//          and EX/MEM. Outputs are combinational from state + inputs.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   branch_ctrl                    00 = PC+4, anything else = redirect
//   ex_mem_read, ex_rd_addr        load in EX and its destination
//   id_rs1/2_addr, id_rs1/2_used   sources of the instruction in ID
//   ex_md_start                    first EX cycle of a mul/div
//   imem_stall, dmem_stall         memory wait
//   pc_write .. exmem_bubble       pipeline register controls
//   md_busy                        mul/div occupying EX
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter int MD_LAT      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        branch_ctrl,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd_addr,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_md_start,
  input  logic              imem_stall,
  input  logic              dmem_stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_write,
  output logic              idex_ctrl_flush,
  output logic              exmem_write,
  output logic              exmem_bubble,
  output logic              md_busy
);

  localparam int CNT_W = cnt_w(LOAD_LAT, FLUSH_DEPTH, MD_LAT);

  localparam logic [CNT_W-1:0] LU_RELOAD    = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_DEPTH - 1);
  localparam logic [CNT_W-1:0] MD_RELOAD    = CNT_W'(MD_LAT - 1);

  hz_state_e        state;
  hz_state_e        state_n;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic             cnt_last;
  logic             redirect;
  logic             lu_hit;

  hz_stall_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .hold     (dmem_stall),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HZ_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // The state is left on the cycle that consumes the final count, so the
  // counter reaches zero together with the return to IDLE.
  assign cnt_last = cnt_zero || (cnt == CNT_W'(1));

  // EX holds the mul/div while MD_BUSY, so no redirect can be genuine then.
  assign redirect = (branch_ctrl != BR_PC4) && (state != HZ_MD_BUSY);

  assign lu_hit = ex_mem_read && (ex_rd_addr != '0) &&
                  ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                   (id_rs2_used && (id_rs2_addr == ex_rd_addr)));

  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_write      = 1'b1;
    idex_ctrl_flush = 1'b0;
    exmem_write     = 1'b1;
    exmem_bubble    = 1'b0;
    md_busy         = 1'b0;
    state_n         = state;
    cnt_load        = 1'b0;
    cnt_load_val    = '0;
    cnt_dec         = 1'b0;

    if (dmem_stall) begin
      // Whole pipeline frozen; state and count hold.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      md_busy     = (state == HZ_MD_BUSY);
    end else if (redirect) begin
      ifid_flush      = 1'b1;
      idex_ctrl_flush = 1'b1;
      if (FLUSH_DEPTH > 1) begin
        state_n      = HZ_FLUSH;
        cnt_load     = 1'b1;
        cnt_load_val = FLUSH_RELOAD;
      end else begin
        state_n = HZ_IDLE;
      end
    end else begin
      case (state)
        HZ_IDLE: begin
          if (ex_md_start) md_busy = 1'b1;
          if (ex_md_start && (MD_LAT > 1)) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            state_n      = HZ_MD_BUSY;
            cnt_load     = 1'b1;
            cnt_load_val = MD_RELOAD;
          end else if (lu_hit) begin
            pc_write        = 1'b0;
            ifid_write      = 1'b0;
            idex_ctrl_flush = 1'b1;
            if (LOAD_LAT > 1) begin
              state_n      = HZ_LU_STALL;
              cnt_load     = 1'b1;
              cnt_load_val = LU_RELOAD;
            end
          end else if (imem_stall) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        HZ_LU_STALL: begin
          pc_write        = 1'b0;
          ifid_write      = 1'b0;
          idex_ctrl_flush = 1'b1;
          cnt_dec         = 1'b1;
          if (cnt_last) state_n = HZ_IDLE;
        end
        HZ_MD_BUSY: begin
          md_busy = 1'b1;
          cnt_dec = 1'b1;
          if (cnt_last) begin
            // Last EX cycle: the result moves on, the pipeline advances.
            state_n = HZ_IDLE;
            if (imem_stall) begin
              pc_write   = 1'b0;
              ifid_flush = 1'b1;
            end
          end else begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
          end
        end
        HZ_FLUSH: begin
          ifid_flush = 1'b1;
          pc_write   = !imem_stall;
          cnt_dec    = 1'b1;
          if (cnt_last) state_n = HZ_IDLE;
        end
        default: begin
          state_n = HZ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - self-checking bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;

  // Output vector order: pc_write, ifid_write, ifid_flush, idex_write,
  // idex_ctrl_flush, exmem_write, exmem_bubble, md_busy
  localparam logic [7:0] O_IDLE   = 8'b1101_0100;
  localparam logic [7:0] O_REDIR  = 8'b1111_1100;
  localparam logic [7:0] O_FLUSH  = 8'b1111_0100;
  localparam logic [7:0] O_LU     = 8'b0001_1100;
  localparam logic [7:0] O_MDST   = 8'b0000_0111;
  localparam logic [7:0] O_MDLAST = 8'b1101_0101;
  localparam logic [7:0] O_FRZ    = 8'b0000_0000;
  localparam logic [7:0] O_FRZMD  = 8'b0000_0001;
  localparam logic [7:0] O_IMEM   = 8'b0111_0100;

  typedef struct packed {
    logic [1:0] br;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       md;
    logic       im;
    logic       dm;
    logic [7:0] ea;
    logic [7:0] eb;
  } cyc_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] branch_ctrl;
  logic       ex_mem_read;
  logic [4:0] ex_rd_addr;
  logic [4:0] id_rs1_addr;
  logic [4:0] id_rs2_addr;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       ex_md_start;
  logic       imem_stall;
  logic       dmem_stall;

  logic pc_write_a, ifid_write_a, ifid_flush_a, idex_write_a;
  logic idex_ctrl_flush_a, exmem_write_a, exmem_bubble_a, md_busy_a;
  logic pc_write_b, ifid_write_b, ifid_flush_b, idex_write_b;
  logic idex_ctrl_flush_b, exmem_write_b, exmem_bubble_b, md_busy_b;
  logic [7:0] out_a;
  logic [7:0] out_b;

  int   tests;
  int   failed;
  exp_t sb[$];

  assign out_a = {pc_write_a, ifid_write_a, ifid_flush_a, idex_write_a,
                  idex_ctrl_flush_a, exmem_write_a, exmem_bubble_a, md_busy_a};
  assign out_b = {pc_write_b, ifid_write_b, ifid_flush_b, idex_write_b,
                  idex_ctrl_flush_b, exmem_write_b, exmem_bubble_b, md_busy_b};

  pipeline_hazard_unit #(
    .REG_AW(5), .LOAD_LAT(2), .FLUSH_DEPTH(3), .MD_LAT(4)
  ) dut_a (
    .clk(clk), .rst(rst), .branch_ctrl(branch_ctrl),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_md_start(ex_md_start), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_write(pc_write_a), .ifid_write(ifid_write_a), .ifid_flush(ifid_flush_a),
    .idex_write(idex_write_a), .idex_ctrl_flush(idex_ctrl_flush_a),
    .exmem_write(exmem_write_a), .exmem_bubble(exmem_bubble_a), .md_busy(md_busy_a)
  );

  pipeline_hazard_unit #(
    .REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(1), .MD_LAT(1)
  ) dut_b (
    .clk(clk), .rst(rst), .branch_ctrl(branch_ctrl),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_md_start(ex_md_start), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_write(pc_write_b), .ifid_write(ifid_write_b), .ifid_flush(ifid_flush_b),
    .idex_write(idex_write_b), .idex_ctrl_flush(idex_ctrl_flush_b),
    .exmem_write(exmem_write_b), .exmem_bubble(exmem_bubble_b), .md_busy(md_busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The environment must never present a redirect while EX holds a mul/div.
  always @(negedge clk) begin
    if (!rst && md_busy_a) begin
      assert (branch_ctrl == 2'b00)
        else $error("redirect presented while mul/div occupies EX");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic cyc_t cy(input int br, input int ld, input int rd, input int rs1,
                              input int rs2, input int u1, input int u2, input int md,
                              input int im, input int dm,
                              input logic [7:0] ea, input logic [7:0] eb);
    cyc_t c;
    c.br = 2'(br);   c.ld = 1'(ld);   c.rd = 5'(rd);
    c.rs1 = 5'(rs1); c.rs2 = 5'(rs2);
    c.u1 = 1'(u1);   c.u2 = 1'(u2);   c.md = 1'(md);
    c.im = 1'(im);   c.dm = 1'(dm);
    c.ea = ea;       c.eb = eb;
    return c;
  endfunction

  function automatic cyc_t nop(input logic [7:0] ea, input logic [7:0] eb);
    return cy(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ea, eb);
  endfunction

  task automatic drive(input cyc_t c);
    branch_ctrl = c.br;  ex_mem_read = c.ld;  ex_rd_addr = c.rd;
    id_rs1_addr = c.rs1; id_rs2_addr = c.rs2;
    id_rs1_used = c.u1;  id_rs2_used = c.u2;
    ex_md_start = c.md;  imem_stall = c.im;   dmem_stall = c.dm;
    sb.push_back('{a: c.ea, b: c.eb});
  endtask

  task automatic test_reset();
    cyc_t t[$];
    exp_t e;
    rst = 1'b1;
    drive(nop(O_IDLE, O_IDLE));
    void'(sb.pop_front());
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    t.push_back(nop(O_IDLE, O_IDLE));
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_MDST, O_MDLAST));
    t.push_back(nop(O_MDST, O_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (out_a !== e.a) begin
        failed++;
        $display("FAIL reset[%0d] dut_a: got %b expected %b", i, out_a, e.a);
      end
      tests++;
      if (out_b !== e.b) begin
        failed++;
        $display("FAIL reset[%0d] dut_b: got %b expected %b", i, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
    // dut_a is mid MD_BUSY here; reset must clear it.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    drive(nop(O_IDLE, O_IDLE));
    @(negedge clk);
    e = sb.pop_front();
    tests++;
    if (out_a !== e.a) begin
      failed++;
      $display("FAIL reset_mid_md dut_a: got %b expected %b", out_a, e.a);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_use();
    cyc_t t[$];
    exp_t e;
    t.push_back(cy(0, 1, 5, 5, 0, 1, 0, 0, 0, 0, O_LU, O_LU));
    t.push_back(nop(O_LU, O_LU));
    t.push_back(nop(O_IDLE, O_LU));
    t.push_back(nop(O_IDLE, O_IDLE));
    t.push_back(cy(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, O_IDLE, O_IDLE));
    t.push_back(cy(0, 1, 7, 3, 7, 1, 0, 0, 0, 0, O_IDLE, O_IDLE));
    t.push_back(cy(0, 0, 9, 9, 9, 1, 1, 0, 0, 0, O_IDLE, O_IDLE));
    t.push_back(cy(0, 1, 7, 3, 7, 1, 1, 0, 0, 0, O_LU, O_LU));
    t.push_back(nop(O_LU, O_LU));
    t.push_back(nop(O_IDLE, O_LU));
    t.push_back(nop(O_IDLE, O_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (out_a !== e.a) begin
        failed++;
        $display("FAIL load_use[%0d] dut_a: got %b expected %b", i, out_a, e.a);
      end
      tests++;
      if (out_b !== e.b) begin
        failed++;
        $display("FAIL load_use[%0d] dut_b: got %b expected %b", i, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_redirect();
    cyc_t t[$];
    exp_t e;
    t.push_back(cy(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_REDIR, O_REDIR));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_IDLE, O_IDLE));
    t.push_back(cy(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_REDIR, O_REDIR));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(cy(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_REDIR, O_REDIR));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_IDLE, O_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (out_a !== e.a) begin
        failed++;
        $display("FAIL redirect[%0d] dut_a: got %b expected %b", i, out_a, e.a);
      end
      tests++;
      if (out_b !== e.b) begin
        failed++;
        $display("FAIL redirect[%0d] dut_b: got %b expected %b", i, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_muldiv();
    cyc_t t[$];
    exp_t e;
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_MDST, O_MDLAST));
    t.push_back(nop(O_MDST, O_IDLE));
    t.push_back(nop(O_MDST, O_IDLE));
    t.push_back(nop(O_MDLAST, O_IDLE));
    t.push_back(nop(O_IDLE, O_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (out_a !== e.a) begin
        failed++;
        $display("FAIL muldiv[%0d] dut_a: got %b expected %b", i, out_a, e.a);
      end
      tests++;
      if (out_b !== e.b) begin
        failed++;
        $display("FAIL muldiv[%0d] dut_b: got %b expected %b", i, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_dmem_freeze();
    cyc_t t[$];
    exp_t e;
    // Freeze inside LU_STALL: dut_b (3-cycle load-use) still totals 3 live stall cycles.
    t.push_back(cy(0, 1, 4, 4, 0, 1, 0, 0, 0, 0, O_LU, O_LU));
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ, O_FRZ));
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZ, O_FRZ));
    t.push_back(nop(O_LU, O_LU));
    t.push_back(nop(O_IDLE, O_LU));
    t.push_back(nop(O_IDLE, O_IDLE));
    // Freeze inside MD_BUSY: md_busy follows the held state.
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_MDST, O_MDLAST));
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, O_FRZMD, O_FRZ));
    t.push_back(nop(O_MDST, O_IDLE));
    t.push_back(nop(O_MDST, O_IDLE));
    t.push_back(nop(O_MDLAST, O_IDLE));
    t.push_back(nop(O_IDLE, O_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (out_a !== e.a) begin
        failed++;
        $display("FAIL dmem_freeze[%0d] dut_a: got %b expected %b", i, out_a, e.a);
      end
      tests++;
      if (out_b !== e.b) begin
        failed++;
        $display("FAIL dmem_freeze[%0d] dut_b: got %b expected %b", i, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_simultaneous();
    cyc_t t[$];
    exp_t e;
    t.push_back(cy(1, 1, 6, 6, 0, 1, 0, 0, 1, 0, O_REDIR, O_REDIR));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_IDLE, O_IDLE));
    t.push_back(cy(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_IMEM, O_IMEM));
    t.push_back(cy(0, 1, 8, 0, 8, 0, 1, 0, 1, 0, O_LU, O_LU));
    t.push_back(cy(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_REDIR, O_REDIR));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_FLUSH, O_IDLE));
    t.push_back(nop(O_IDLE, O_IDLE));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      e = sb.pop_front();
      tests++;
      if (out_a !== e.a) begin
        failed++;
        $display("FAIL simultaneous[%0d] dut_a: got %b expected %b", i, out_a, e.a);
      end
      tests++;
      if (out_b !== e.b) begin
        failed++;
        $display("FAIL simultaneous[%0d] dut_b: got %b expected %b", i, out_b, e.b);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    test_reset();
    test_load_use();
    test_redirect();
    test_muldiv();
    test_dmem_freeze();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
